// File: rtl/sram_port_arbiter_if.sv
// Client-side command bus of sram_port_arbiter: per-client req/we/addr/wdata in,
// one-hot gnt/rvalid and shared rdata out.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int NCLI   = 3
);
  logic [NCLI-1:0]        i_req;
  logic [NCLI-1:0]        i_we;
  logic [NCLI*ADDR_W-1:0] i_addr;
  logic [NCLI*DATA_W-1:0] i_wdata;
  logic [NCLI-1:0]        o_gnt;
  logic [NCLI-1:0]        o_rvalid;
  logic [DATA_W-1:0]      o_rdata;
  logic                   o_busy;

  modport master (
    output i_req, i_we, i_addr, i_wdata,
    input  o_gnt, o_rvalid, o_rdata, o_busy
  );

  modport slave (
    input  i_req, i_we, i_addr, i_wdata,
    output o_gnt, o_rvalid, o_rdata, o_busy
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Three-client arbiter and pin sequencer for a 16-bit async SRAM.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (0 highest).
//
// state  | meaning
// IDLE   | arbitrate; on a request latch the command and pulse o_gnt
// ACCESS | granted command is handed to the SRAM pin registers
// TURN   | dead cycle after a write before the next command may be granted
module sram_port_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int NCLI   = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  sram_port_arbiter_if.slave bus,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_WE_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_UB_N
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] TURN   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [NCLI-1:0]   gnt_q, gnt_d;
  logic [NCLI-1:0]   rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cmd_we_q, cmd_we_d;
  logic [1:0]        cmd_cli_q, cmd_cli_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic              rd_pend_q, rd_pend_d;

  logic [1:0]        win;
  logic              win_vld;
  logic              acc_rd;
  logic              acc_wr;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic [1:0]        ptr_q, ptr_d;

  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int j = 0; j < NCLI; j++) begin
      idx = (int'(ptr_q) + 1 + j) % NCLI;
      if (!win_vld && bus.i_req[idx]) begin
        win_vld = 1'b1;
        win     = 2'(idx);
      end
    end
  end
`else
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int k = NCLI - 1; k >= 0; k--) begin
      if (bus.i_req[k]) begin
        win_vld = 1'b1;
        win     = 2'(k);
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cmd_we_d  = cmd_we_q;
    cmd_cli_d = cmd_cli_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d   = ACCESS;
          gnt_d     = NCLI'(1) << win;
          addr_d    = bus.i_addr[int'(win)*ADDR_W +: ADDR_W];
          wdata_d   = bus.i_wdata[int'(win)*DATA_W +: DATA_W];
          cmd_we_d  = bus.i_we[win];
          cmd_cli_d = win;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
          ptr_d     = win;
`endif
        end
      end
      ACCESS:  state_d = cmd_we_q ? TURN : IDLE;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Pin registers run one cycle behind the FSM: the SRAM cycle happens in the
  // cycle after o_gnt, while addr/wdata/client are still the granted ones.
  assign acc_rd = (state_q == ACCESS) && !cmd_we_q;
  assign acc_wr = (state_q == ACCESS) &&  cmd_we_q;

  always_comb begin
    ce_n_d    = !(acc_rd || acc_wr);
    oe_n_d    = !acc_rd;
    we_n_d    = !acc_wr;
    dq_oe_d   = acc_wr;
    rd_pend_d = acc_rd;
    rdata_d   = rd_pend_q ? SRAM_DQ : rdata_q;
    rvalid_d  = rd_pend_q ? (NCLI'(1) << cmd_cli_q) : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cmd_we_q  <= 1'b0;
      cmd_cli_q <= '0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      dq_oe_q   <= 1'b0;
      rd_pend_q <= 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      ptr_q     <= 2'(NCLI - 1);
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cmd_we_q  <= cmd_we_d;
      cmd_cli_q <= cmd_cli_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      dq_oe_q   <= dq_oe_d;
      rd_pend_q <= rd_pend_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign SRAM_DQ      = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
  assign SRAM_ADDR    = addr_q;
  assign SRAM_CE_N    = ce_n_q;
  assign SRAM_OE_N    = oe_n_q;
  assign SRAM_WE_N    = we_n_q;
  assign SRAM_LB_N    = 1'b0;
  assign SRAM_UB_N    = 1'b0;

  assign bus.o_gnt    = gnt_q;
  assign bus.o_rvalid = rvalid_q;
  assign bus.o_rdata  = rdata_q;
  assign bus.o_busy   = busy_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small behavioural async SRAM model.
module tb_sram_port_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  wire  [15:0] sram_dq;
  logic [19:0] sram_addr;
  logic        sram_we_n, sram_ce_n, sram_oe_n, sram_lb_n, sram_ub_n;

  int checks = 0;
  int errors = 0;
  int contention = 0;
  int hit30 = 0;

  logic [15:0] mem [0:63];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  logic [15:0] rd_word;

  sram_port_arbiter_if #(.ADDR_W(20), .DATA_W(16), .NCLI(3)) ifc ();

  sram_port_arbiter dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .bus       (ifc),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (sram_we_n),
    .SRAM_CE_N (sram_ce_n),
    .SRAM_OE_N (sram_oe_n),
    .SRAM_LB_N (sram_lb_n),
    .SRAM_UB_N (sram_ub_n)
  );

  always #5 i_clk = ~i_clk;

  assign rd_word = mem[sram_addr[5:0]];
  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? rd_word : 16'hzzzz;

  always @(posedge i_clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (!sram_ce_n && !sram_we_n) mem[sram_addr[5:0]] <= sram_dq;
  end

  always @(negedge i_clk) begin
    if (!i_rst && !sram_oe_n && !sram_we_n) contention++;
    if (!sram_ce_n && sram_addr == 20'h00030) hit30++;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    tick();
    pre_en   = 1'b0;
  endtask

  task automatic set_cli(input int k, input logic req, input logic we,
                         input logic [19:0] a, input logic [15:0] d);
    ifc.i_req[k]           = req;
    ifc.i_we[k]            = we;
    ifc.i_addr[k*20 +: 20] = a;
    ifc.i_wdata[k*16 +: 16] = d;
  endtask

  logic [2:0]  one = 3'b001;
  logic [31:0] zz  = 32'h0000zzzz;
  int          exp_cli [0:5];

  initial begin
    i_rst       = 1'b1;
    ifc.i_req   = '0;
    ifc.i_we    = '0;
    ifc.i_addr  = '0;
    ifc.i_wdata = '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    exp_cli = '{0, 1, 2, 0, 1, 2};
`else
    exp_cli = '{0, 0, 0, 0, 0, 0};
`endif
    tick();
    preload(6'h10, 16'hBEEF);
    preload(6'h20, 16'hC000);
    preload(6'h21, 16'hC001);
    preload(6'h22, 16'hC002);
    tick();

    // reset state
    chk("rst_ce_n",   {31'd0, sram_ce_n}, 32'd1);
    chk("rst_we_n",   {31'd0, sram_we_n}, 32'd1);
    chk("rst_oe_n",   {31'd0, sram_oe_n}, 32'd1);
    chk("rst_lb_ub",  {30'd0, sram_lb_n, sram_ub_n}, 32'd0);
    chk("rst_gnt",    {29'd0, ifc.o_gnt}, 32'd0);
    chk("rst_rvalid", {29'd0, ifc.o_rvalid}, 32'd0);
    chk("rst_rdata",  {16'd0, ifc.o_rdata}, 32'd0);
    chk("rst_busy",   {31'd0, ifc.o_busy}, 32'd0);
    chk("rst_addr",   {12'd0, sram_addr}, 32'd0);
    chk("rst_dq",     {16'd0, sram_dq}, zz);
    i_rst = 1'b0;
    tick();
    chk("idle_ce_n",  {31'd0, sram_ce_n}, 32'd1);

    // client 1 read of 0x00010
    set_cli(1, 1'b1, 1'b0, 20'h00010, 16'h0);
    tick();
    chk("rd_gnt",     {29'd0, ifc.o_gnt}, 32'b010);
    chk("rd_busy",    {31'd0, ifc.o_busy}, 32'd1);
    chk("rd_oe_t0",   {31'd0, sram_oe_n}, 32'd1);
    ifc.i_req[1] = 1'b0;
    tick();
    chk("rd_oe_t1",   {31'd0, sram_oe_n}, 32'd0);
    chk("rd_ce_t1",   {31'd0, sram_ce_n}, 32'd0);
    chk("rd_addr_t1", {12'd0, sram_addr}, 32'h10);
    chk("rd_gnt_t1",  {29'd0, ifc.o_gnt}, 32'd0);
    tick();
    chk("rd_rvalid",  {29'd0, ifc.o_rvalid}, 32'b010);
    chk("rd_rdata",   {16'd0, ifc.o_rdata}, 32'hBEEF);
    chk("rd_oe_t2",   {31'd0, sram_oe_n}, 32'd1);

    // client 0 write 0x1234 @2, then client 1 read @2
    set_cli(0, 1'b1, 1'b1, 20'h00002, 16'h1234);
    tick();
    chk("wr_gnt",     {29'd0, ifc.o_gnt}, 32'b001);
    ifc.i_req[0] = 1'b0;
    set_cli(1, 1'b1, 1'b0, 20'h00002, 16'h0);
    tick();
    chk("wr_we_n",    {31'd0, sram_we_n}, 32'd0);
    chk("wr_oe_n",    {31'd0, sram_oe_n}, 32'd1);
    chk("wr_dq",      {16'd0, sram_dq}, 32'h1234);
    tick();
    chk("turn_we_n",  {31'd0, sram_we_n}, 32'd1);
    chk("turn_ce_n",  {31'd0, sram_ce_n}, 32'd1);
    chk("turn_dq",    {16'd0, sram_dq}, zz);
    chk("turn_gnt",   {29'd0, ifc.o_gnt}, 32'd0);
    tick();
    chk("wr_rd_gnt",  {29'd0, ifc.o_gnt}, 32'b010);
    ifc.i_req[1] = 1'b0;
    tick();
    chk("wr_rd_oe",   {31'd0, sram_oe_n}, 32'd0);
    tick();
    chk("wr_rd_rv",   {29'd0, ifc.o_rvalid}, 32'b010);
    chk("wr_rd_data", {16'd0, ifc.o_rdata}, 32'h1234);
    chk("contention", contention, 32'd0);

    // reset in the middle of a write
    set_cli(0, 1'b1, 1'b1, 20'h00005, 16'h5555);
    tick();
    chk("mid_gnt",    {29'd0, ifc.o_gnt}, 32'b001);
    ifc.i_req[0] = 1'b0;
    tick();
    chk("mid_we_n",   {31'd0, sram_we_n}, 32'd0);
    i_rst = 1'b1;
    tick();
    chk("mrst_ce_n",  {31'd0, sram_ce_n}, 32'd1);
    chk("mrst_we_n",  {31'd0, sram_we_n}, 32'd1);
    chk("mrst_dq",    {16'd0, sram_dq}, zz);
    chk("mrst_gnt",   {29'd0, ifc.o_gnt}, 32'd0);
    chk("mrst_rv",    {29'd0, ifc.o_rvalid}, 32'd0);
    chk("mrst_busy",  {31'd0, ifc.o_busy}, 32'd0);
    tick();
    i_rst = 1'b0;
    tick();

    // all three clients hold read requests
    for (int k = 0; k < 3; k++) set_cli(k, 1'b1, 1'b0, 20'h00020 + 20'(k), 16'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("all_gnt", {29'd0, ifc.o_gnt}, {29'd0, one << exp_cli[i]});
      if (i > 0) begin
        chk("all_rv",    {29'd0, ifc.o_rvalid}, {29'd0, one << exp_cli[i-1]});
        chk("all_rdata", {16'd0, ifc.o_rdata}, 32'hC000 + 32'(exp_cli[i-1]));
      end
      if (i == 5) ifc.i_req = '0;
      tick();
      chk("all_gap",   {29'd0, ifc.o_gnt}, 32'd0);
    end
    tick();
    chk("all_rv_last", {29'd0, ifc.o_rvalid}, {29'd0, one << exp_cli[5]});
    tick();

    // client 2 cancels while client 0 holds the SRAM
    hit30 = 0;
    set_cli(0, 1'b1, 1'b1, 20'h00004, 16'h4444);
    set_cli(2, 1'b1, 1'b0, 20'h00030, 16'h0);
    tick();
    chk("cxl_gnt0",   {29'd0, ifc.o_gnt}, 32'b001);
    ifc.i_req = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("cxl_no_gnt2", {31'd0, ifc.o_gnt[2]}, 32'd0);
    end
    chk("cxl_no_cycle", hit30, 32'd0);

    // back-to-back reads by client 1 @0..7
    for (int a = 0; a < 8; a++) preload(6'(a), 16'hA000 + 16'(a));
    set_cli(1, 1'b1, 1'b0, 20'h00000, 16'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("b2b_gnt", {29'd0, ifc.o_gnt}, 32'b010);
      if (i > 0) begin
        chk("b2b_rv",    {29'd0, ifc.o_rvalid}, 32'b010);
        chk("b2b_rdata", {16'd0, ifc.o_rdata}, 32'hA000 + 32'(i - 1));
      end
      if (i == 7) ifc.i_req[1] = 1'b0;
      else        ifc.i_addr[20 +: 20] = 20'(i + 1);
      tick();
      chk("b2b_gap",   {29'd0, ifc.o_gnt}, 32'd0);
    end
    tick();
    chk("b2b_rv_last",    {29'd0, ifc.o_rvalid}, 32'b010);
    chk("b2b_rdata_last", {16'd0, ifc.o_rdata}, 32'hA007);
    chk("contention_end", contention, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
